// File: rtl/nibble_sort_pkg.sv
// ============================================================================
// Module      : nibble_sort_pkg
// Description : Shared state encoding, default sizes and size helpers for
//               the nibble_sort_ctrl bubble-sort sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package nibble_sort_pkg;

    localparam int DEF_WIDTH = 4;
    localparam int DEF_DEPTH = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CMP  = 2'd1,
        DONE = 2'd2
    } state_e;

    // Compare-and-swap steps in a full bubble sort of depth elements
    function automatic int calc_ncmp(input int depth);
        return depth * (depth - 1) / 2;
    endfunction

    function automatic int calc_cnt_w(input int depth);
        return $clog2(calc_ncmp(depth) + 1);
    endfunction

endpackage

`default_nettype wire

// File: rtl/nibble_sort_ctrl_mag_cmp.sv
// ============================================================================
// Module      : mag_cmp
// Description : WIDTH-bit unsigned magnitude comparator (a vs b).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mag_cmp #(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             equal,
    output logic             a_big,
    output logic             b_big
);

    assign equal = (a == b);
    assign a_big = (a > b);
    assign b_big = (a < b);

endmodule

`default_nettype wire

// File: rtl/nibble_sort_ctrl.sv
// ============================================================================
// Module      : nibble_sort_ctrl
// Description : Bubble-sort sequencer, one compare-and-swap per cycle on a
//               single shared comparator. Optional macro
//               NIBBLE_SORT_EARLY_EXIT_EN ends the sort after a swap-free pass.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module nibble_sort_ctrl
    import nibble_sort_pkg::*;
#(
    parameter  int WIDTH = DEF_WIDTH,
    parameter  int DEPTH = DEF_DEPTH,
    localparam int CNT_W = calc_cnt_w(DEPTH)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic [WIDTH*DEPTH-1:0] din,
    output logic                   busy,
    output logic                   done,
    output logic [WIDTH*DEPTH-1:0] dout,
    output logic [CNT_W-1:0]       swap_cnt
);

    localparam int IDX_W = $clog2(DEPTH);

    state_e             state_q, state_d;
    logic [WIDTH-1:0]   elem_q [DEPTH];
    logic [WIDTH-1:0]   elem_d [DEPTH];
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [IDX_W-1:0]   pass_q, pass_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
`ifdef NIBBLE_SORT_EARLY_EXIT_EN
    logic               swapped_q, swapped_d;
`endif

    logic [IDX_W-1:0]   idx_nxt;
    logic [IDX_W-1:0]   idx_last;
    logic [WIDTH-1:0]   cmp_a, cmp_b;
    logic               cmp_eq, cmp_a_big, cmp_b_big;
    logic               do_swap;

    assign idx_nxt  = idx_q + IDX_W'(1);
    assign idx_last = IDX_W'(DEPTH - 2) - pass_q;
    assign cmp_a    = elem_q[idx_q];
    assign cmp_b    = elem_q[idx_nxt];

    mag_cmp #(
        .WIDTH (WIDTH)
    ) u_mag_cmp (
        .a     (cmp_a),
        .b     (cmp_b),
        .equal (cmp_eq),
        .a_big (cmp_a_big),
        .b_big (cmp_b_big)
    );

    // Ties never swap, which keeps the sort stable
    assign do_swap = cmp_a_big & ~cmp_eq & ~cmp_b_big;

    always_comb begin
        state_d = state_q;
        elem_d  = elem_q;
        idx_d   = idx_q;
        pass_d  = pass_q;
        cnt_d   = cnt_q;
`ifdef NIBBLE_SORT_EARLY_EXIT_EN
        swapped_d = swapped_q;
`endif
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = CMP;
                    idx_d   = '0;
                    pass_d  = '0;
                    cnt_d   = '0;
`ifdef NIBBLE_SORT_EARLY_EXIT_EN
                    swapped_d = 1'b0;
`endif
                    for (int i = 0; i < DEPTH; i++) begin
                        elem_d[i] = din[i*WIDTH +: WIDTH];
                    end
                end
            end
            CMP: begin
                if (do_swap) begin
                    elem_d[idx_q]   = cmp_b;
                    elem_d[idx_nxt] = cmp_a;
                    cnt_d           = cnt_q + CNT_W'(1);
                end
                if (idx_q == idx_last) begin
                    idx_d  = '0;
                    pass_d = pass_q + IDX_W'(1);
`ifdef NIBBLE_SORT_EARLY_EXIT_EN
                    swapped_d = 1'b0;
                    if ((pass_q == IDX_W'(DEPTH - 2)) || !(swapped_q || do_swap)) begin
                        state_d = DONE;
                    end
`else
                    if (pass_q == IDX_W'(DEPTH - 2)) begin
                        state_d = DONE;
                    end
`endif
                end else begin
                    idx_d = idx_nxt;
`ifdef NIBBLE_SORT_EARLY_EXIT_EN
                    swapped_d = swapped_q | do_swap;
`endif
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            idx_q   <= '0;
            pass_q  <= '0;
            cnt_q   <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                elem_q[i] <= '0;
            end
`ifdef NIBBLE_SORT_EARLY_EXIT_EN
            swapped_q <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            pass_q  <= pass_d;
            cnt_q   <= cnt_d;
            for (int i = 0; i < DEPTH; i++) begin
                elem_q[i] <= elem_d[i];
            end
`ifdef NIBBLE_SORT_EARLY_EXIT_EN
            swapped_q <= swapped_d;
`endif
        end
    end

    assign busy     = (state_q != IDLE);
    assign done     = (state_q == DONE);
    assign swap_cnt = cnt_q;

    for (genvar g = 0; g < DEPTH; g++) begin : g_pack
        assign dout[g*WIDTH +: WIDTH] = elem_q[g];
    end

endmodule

`default_nettype wire

// File: tb/tb_nibble_sort_ctrl.sv
// ============================================================================
// Module      : tb_nibble_sort_ctrl
// Description : Scoreboard testbench for nibble_sort_ctrl (WIDTH=4, DEPTH=4).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_nibble_sort_ctrl;

    localparam int W  = 4;
    localparam int D  = 4;
    localparam int DW = W * D;
    localparam int CW = 3;

    typedef struct packed {
        logic [DW-1:0] dout;
        logic [CW-1:0] cnt;
        int            lat;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic [DW-1:0] din = '0;
    logic          busy;
    logic          done;
    logic [DW-1:0] dout;
    logic [CW-1:0] swap_cnt;

    int   n_cmp  = 0;
    int   n_fail = 0;
    exp_t sb[$];

    nibble_sort_ctrl #(
        .WIDTH (W),
        .DEPTH (D)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .din      (din),
        .busy     (busy),
        .done     (done),
        .dout     (dout),
        .swap_cnt (swap_cnt)
    );

    always #5 clk = ~clk;

    // Reference: stable insertion sort, inversion count, pass count from
    // the largest number of greater elements sitting left of any element.
    function automatic exp_t model(input logic [DW-1:0] v);
        exp_t         e;
        logic [W-1:0] a [D];
        logic [W-1:0] s [D];
        logic [W-1:0] key;
        int           j, inv, k, kj, passes;
        for (int i = 0; i < D; i++) begin
            a[i] = v[i*W +: W];
            s[i] = a[i];
        end
        for (int i = 1; i < D; i++) begin
            key = s[i];
            j = i - 1;
            while (j >= 0 && s[j] > key) begin
                s[j+1] = s[j];
                j--;
            end
            s[j+1] = key;
        end
        inv = 0;
        k = 0;
        for (int jj = 0; jj < D; jj++) begin
            kj = 0;
            for (int ii = 0; ii < jj; ii++) if (a[ii] > a[jj]) kj++;
            inv += kj;
            if (kj > k) k = kj;
        end
        passes = (k + 1 < D - 1) ? k + 1 : D - 1;
`ifdef NIBBLE_SORT_EARLY_EXIT_EN
        e.lat = 1;
        for (int p = 0; p < passes; p++) e.lat += D - 1 - p;
`else
        e.lat = D * (D - 1) / 2 + 1;
`endif
        for (int i = 0; i < D; i++) e.dout[i*W +: W] = s[i];
        e.cnt = CW'(inv);
        return e;
    endfunction

    // mode 0: plain, 1: extra start + new din at T+3, 2: rst at T+3,
    // 3: return in the DONE cycle so the next call can test back-to-back
    task automatic run_sort(input logic [DW-1:0] v, input int wait_edges,
                            input int mode, input logic [DW-1:0] alt);
        exp_t e;
        int   waited;
        int   cyc;
        bit   seen;
        sb.push_back(model(v));
        @(negedge clk);
        din   = v;
        start = 1'b1;
        waited = 0;
        while (waited < 5) begin
            @(posedge clk);
            #1;
            waited++;
            if (busy === 1'b1) break;
        end
        start = 1'b0;
        din   = ~v;
        n_cmp++;
        if (waited != wait_edges || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL accept: busy=%0b after %0d edges, expected busy=1 after %0d",
                     busy, waited, wait_edges);
        end
        seen = 1'b0;
        cyc  = 1;
        while (cyc < 40) begin
            if (cyc > 1) begin
                @(posedge clk);
                #1;
            end
            if (mode == 1 && cyc == 3) begin
                start = 1'b1;
                din   = alt;
            end
            if (mode == 1 && cyc == 4) start = 1'b0;
            if (mode == 2 && cyc == 3) begin
                rst = 1'b1;
                break;
            end
            n_cmp++;
            if (busy !== 1'b1) begin
                n_fail++;
                $display("FAIL busy_hold: busy=%0b at T+%0d, expected 1", busy, cyc);
            end
            if (done === 1'b1) begin
                seen = 1'b1;
                break;
            end
            cyc++;
        end
        e = sb.pop_front();
        if (mode == 2) begin
            @(posedge clk);
            #1;
            rst = 1'b0;
            n_cmp++;
            if (busy !== 1'b0 || done !== 1'b0) begin
                n_fail++;
                $display("FAIL rst_ctrl: busy=%0b done=%0b, expected 0 0", busy, done);
            end
            n_cmp++;
            if (dout !== '0 || swap_cnt !== '0) begin
                n_fail++;
                $display("FAIL rst_data: dout=%h swap_cnt=%0d, expected 0000 0", dout, swap_cnt);
            end
            return;
        end
        n_cmp++;
        if (!seen) begin
            n_fail++;
            $display("FAIL done_timeout: no done within 40 cycles for din=%h", v);
        end
        n_cmp++;
        if (cyc != e.lat) begin
            n_fail++;
            $display("FAIL latency: done at T+%0d, expected T+%0d (din=%h)", cyc, e.lat, v);
        end
        n_cmp++;
        if (dout !== e.dout) begin
            n_fail++;
            $display("FAIL dout: got %h, expected %h (din=%h)", dout, e.dout, v);
        end
        n_cmp++;
        if (swap_cnt !== e.cnt) begin
            n_fail++;
            $display("FAIL swap_cnt: got %0d, expected %0d (din=%h)", swap_cnt, e.cnt, v);
        end
        if (mode != 3) begin
            @(posedge clk);
            #1;
            n_cmp++;
            if (done !== 1'b0 || busy !== 1'b0) begin
                n_fail++;
                $display("FAIL done_pulse: done=%0b busy=%0b after DONE, expected 0 0", done, busy);
            end
            n_cmp++;
            if (dout !== e.dout || swap_cnt !== e.cnt) begin
                n_fail++;
                $display("FAIL hold: dout=%h cnt=%0d, expected %h %0d", dout, swap_cnt, e.dout, e.cnt);
            end
        end
    endtask

    task automatic test_reset();
        rst   = 1'b1;
        start = 1'b1;
        din   = 16'hFFFF;
        repeat (3) @(posedge clk);
        #1;
        n_cmp++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_ctrl: busy=%0b done=%0b, expected 0 0", busy, done);
        end
        n_cmp++;
        if (dout !== '0 || swap_cnt !== '0) begin
            n_fail++;
            $display("FAIL reset_data: dout=%h swap_cnt=%0d, expected 0000 0", dout, swap_cnt);
        end
        @(negedge clk);
        rst   = 1'b0;
        start = 1'b0;
    endtask

    task automatic test_directed();
        run_sort(16'h1234, 1, 0, '0);   // 4,3,2,1
        run_sort(16'h4321, 1, 0, '0);   // 1,2,3,4
        run_sort(16'h5055, 1, 0, '0);   // 5,5,0,5
        run_sort(16'h0F0F, 1, 0, '0);   // F,0,F,0
    endtask

    task automatic test_random();
        logic [DW-1:0] v;
        for (int n = 0; n < 8; n++) begin
            v = DW'($urandom);
            run_sort(v, 1, 0, '0);
        end
    endtask

    task automatic test_start_ignored();
        run_sort(16'h2A71, 1, 1, 16'h0000);
    endtask

    task automatic test_rst_mid();
        run_sort(16'h1234, 1, 2, '0);
        run_sort(16'h9C3E, 1, 0, '0);
    endtask

    task automatic test_back_to_back();
        run_sort(16'h8D06, 1, 3, '0);
        run_sort(16'h3B7F, 2, 0, '0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_directed();
        test_random();
        test_start_ignored();
        test_rst_mid();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
